// File: rtl/spi_flash_pkg.sv
// Shared command codes, FSM state encoding and JEDEC byte selection for the
// SPI flash read-side responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        STATUS,
        IGNORE
    } state_t;

    // Byte idx of the JEDEC identifier, MSB byte first; past the third byte it reads zero.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            2'd2:    return id[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the synchronous byte-read memory port of the flash responder.
interface spi_flash_responder_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  spi_sclk;
    logic                  spi_ss;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [7:0]            mem_data;
    logic                  busy;

    modport slave (
        input  spi_sclk, spi_ss, spi_mosi, mem_data,
        output spi_miso, spi_miso_oe, mem_addr, mem_rd, busy
    );

    modport master (
        output spi_sclk, spi_ss, spi_mosi, mem_data,
        input  spi_miso, spi_miso_oe, mem_addr, mem_rd, busy
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for the {sclk, ss, mosi} pin bundle with edge
// detection on sclk and ss.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pins,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       ss_rise,
    output logic       ss_fall,
    output logic       ss_level,
    output logic       mosi_level
);
    logic [STAGES-1:0][2:0] chain;
    logic                   sclk_prev;
    logic                   ss_prev;

    // ss resets low so that a chip select already asserted at reset release
    // produces no falling edge until it has been seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain     <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            chain     <= {chain[STAGES-2:0], pins};
            sclk_prev <= chain[STAGES-1][2];
            ss_prev   <= chain[STAGES-1][1];
        end
    end

    assign sclk_rise  =  chain[STAGES-1][2] & ~sclk_prev;
    assign sclk_fall  = ~chain[STAGES-1][2] &  sclk_prev;
    assign ss_rise    =  chain[STAGES-1][1] & ~ss_prev;
    assign ss_fall    = ~chain[STAGES-1][1] &  ss_prev;
    assign ss_level   =  chain[STAGES-1][1];
    assign mosi_level =  chain[STAGES-1][0];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating the read side of a serial NOR flash
// (READ, READ STATUS, JEDEC ID), fully oversampled in the io_clock domain.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  io_clock,
    input  logic                  io_reset,
    spi_flash_responder_if.slave  io
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_level, mosi;

    state_t                state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            cmd_q, cmd_d;
    logic [ADDR_WIDTH-2:0] addr_sr_q, addr_sr_d;
    logic [7:0]            tx_q, tx_d;
    logic [7:0]            hold_q, hold_d;
    logic [2:0]            fall_cnt_q, fall_cnt_d;
    logic [2:0]            rise_cnt_q, rise_cnt_d;
    logic [1:0]            id_idx_q, id_idx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  to_hold_q, to_hold_d;
    logic                  miso_q, miso_d;
    logic                  armed_q, armed_d;
    logic                  oe;

    spi_pin_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (io_clock),
        .rst        (io_reset),
        .pins       ({io.spi_sclk, io.spi_ss, io.spi_mosi}),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .ss_rise    (ss_rise),
        .ss_fall    (ss_fall),
        .ss_level   (ss_level),
        .mosi_level (mosi)
    );

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            addr_sr_q  <= '0;
            tx_q       <= '0;
            hold_q     <= '0;
            fall_cnt_q <= '0;
            rise_cnt_q <= '0;
            id_idx_q   <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            to_hold_q  <= 1'b0;
            miso_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            addr_sr_q  <= addr_sr_d;
            tx_q       <= tx_d;
            hold_q     <= hold_d;
            fall_cnt_q <= fall_cnt_d;
            rise_cnt_q <= rise_cnt_d;
            id_idx_q   <= id_idx_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            rd_valid_q <= rd_valid_d;
            to_hold_q  <= to_hold_d;
            miso_q     <= miso_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        addr_sr_d  = addr_sr_q;
        tx_d       = tx_q;
        hold_d     = hold_q;
        fall_cnt_d = fall_cnt_q;
        rise_cnt_d = rise_cnt_q;
        id_idx_d   = id_idx_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        rd_valid_d = mem_rd_q;
        to_hold_d  = to_hold_q;
        miso_d     = miso_q;
        armed_d    = armed_q | ss_level;

        // Memory data arrives the cycle after the strobe; the first byte goes
        // straight to the shifter, prefetches park in the holding register.
        if (rd_valid_q && state_q == DATA) begin
            if (to_hold_q) hold_d = io.mem_data;
            else           tx_d   = io.mem_data;
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    cmd_d     = {cmd_q[5:0], mosi};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d  = '0;
                        fall_cnt_d = '0;
                        rise_cnt_d = '0;
                        case ({cmd_q, mosi})
                            CMD_READ: state_d = ADDR;
                            CMD_RDID: begin
                                state_d  = ID;
                                tx_d     = id_byte(JEDEC_ID, 2'd0);
                                id_idx_d = 2'd1;
                            end
                            CMD_RDSR: begin
                                state_d = STATUS;
                                tx_d    = 8'h00;
                            end
                            default:  state_d = IGNORE;
                        endcase
                    end
                end
            end
            ADDR: begin
                if (sclk_rise) begin
                    addr_sr_d = {addr_sr_q[ADDR_WIDTH-3:0], mosi};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        mem_addr_d = {addr_sr_q, mosi};
                        mem_rd_d   = 1'b1;
                        to_hold_d  = 1'b0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    rise_cnt_d = rise_cnt_q + 3'd1;
                    if (rise_cnt_q == 3'd0) begin
                        mem_addr_d = mem_addr_q + ADDR_ONE;
                        mem_rd_d   = 1'b1;
                        to_hold_d  = 1'b1;
                    end
                end
                if (sclk_fall) begin
                    miso_d     = tx_q[7];
                    tx_d       = {tx_q[6:0], 1'b0};
                    fall_cnt_d = fall_cnt_q + 3'd1;
                    if (fall_cnt_q == 3'd7) tx_d = hold_q;
                end
            end
            ID: begin
                if (sclk_fall) begin
                    miso_d     = tx_q[7];
                    tx_d       = {tx_q[6:0], 1'b0};
                    fall_cnt_d = fall_cnt_q + 3'd1;
                    if (fall_cnt_q == 3'd7) begin
                        tx_d = id_byte(JEDEC_ID, id_idx_q);
                        if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                    end
                end
            end
            STATUS: begin
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            default: ;
        endcase

        // A deselect overrides everything, including a strobe raised this cycle.
        if (ss_rise) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            cmd_d      = '0;
            addr_sr_d  = '0;
            tx_d       = '0;
            hold_d     = '0;
            fall_cnt_d = '0;
            rise_cnt_d = '0;
            id_idx_d   = '0;
            mem_rd_d   = 1'b0;
            rd_valid_d = 1'b0;
            miso_d     = 1'b0;
        end
    end

    assign oe             = armed_q & ~ss_level;
    assign io.spi_miso_oe = oe;
    assign io.busy        = oe;
    assign io.spi_miso    = miso_q & oe;
    assign io.mem_addr    = mem_addr_q;
    assign io.mem_rd      = mem_rd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed self-checking bench for spi_flash_responder with SCLK = io_clock/8
// and a memory holding addr[7:0]^8'h5A.
module tb_spi_flash_responder;

    logic io_clock = 1'b0;
    logic io_reset;

    int n_compared   = 0;
    int n_mismatched = 0;

    int rd_count = 0;
    int rd_runs  = 0;
    int oe_hi    = 0;
    int busy_hi  = 0;
    int miso_hi  = 0;
    logic rd_prev = 1'b0;
    logic [15:0] rd_log [64];

    spi_flash_responder_if #(.ADDR_WIDTH(16)) bus ();

    spi_flash_responder #(
        .ADDR_WIDTH (16),
        .JEDEC_ID   (24'hEF4016),
        .SYNC_STAGES(2)
    ) dut (
        .io_clock (io_clock),
        .io_reset (io_reset),
        .io       (bus)
    );

    always #5 io_clock = ~io_clock;

    always @(posedge io_clock) begin
        if (bus.mem_rd) bus.mem_data <= bus.mem_addr[7:0] ^ 8'h5A;
    end

    always @(negedge io_clock) begin
        if (bus.mem_rd) begin
            rd_log[rd_count % 64] <= bus.mem_addr;
            rd_count <= rd_count + 1;
        end
        if (bus.mem_rd && rd_prev) rd_runs <= rd_runs + 1;
        rd_prev <= bus.mem_rd;
        if (bus.spi_miso_oe) oe_hi <= oe_hi + 1;
        if (bus.busy)        busy_hi <= busy_hi + 1;
        if (bus.spi_miso)    miso_hi <= miso_hi + 1;
    end

    task automatic spi_bit(input logic b, output logic r);
        bus.spi_mosi = b;
        repeat (4) @(negedge io_clock);
        r = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        repeat (4) @(negedge io_clock);
        bus.spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic ss_begin();
        bus.spi_ss = 1'b0;
        repeat (4) @(negedge io_clock);
    endtask

    task automatic ss_end();
        repeat (4) @(negedge io_clock);
        bus.spi_ss = 1'b1;
        repeat (8) @(negedge io_clock);
    endtask

    task automatic send_read(input logic [23:0] a);
        logic [7:0] rx;
        spi_byte(8'h03, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
    endtask

    task automatic test_reset();
        io_reset = 1'b1;
        repeat (3) @(negedge io_clock);
        n_compared++;
        if (bus.spi_miso !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_miso: got %b expected 0", bus.spi_miso); end
        n_compared++;
        if (bus.spi_miso_oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_oe: got %b expected 0", bus.spi_miso_oe); end
        n_compared++;
        if (bus.mem_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0000", bus.mem_addr); end
        n_compared++;
        if (bus.mem_rd !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rd: got %b expected 0", bus.mem_rd); end
        n_compared++;
        if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        io_reset = 1'b0;
        repeat (6) @(negedge io_clock);
    endtask

    task automatic test_read();
        logic [7:0] exp_data [4] = '{8'h4A, 8'h4B, 8'h48, 8'h49};
        logic [7:0] rx;
        int base = rd_count;
        int runs = rd_runs;
        ss_begin();
        send_read(24'h000010);
        n_compared++;
        if (bus.busy !== 1'b1 || bus.spi_miso_oe !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL read_busy_oe: got %b/%b expected 1/1", bus.busy, bus.spi_miso_oe);
        end
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, rx);
            n_compared++;
            if (rx !== exp_data[k]) begin n_mismatched++; $display("[TB] FAIL read_byte%0d: got %h expected %h", k, rx, exp_data[k]); end
        end
        ss_end();
        // Four data fetches plus the prefetch issued on the fourth byte's bit-7 rise.
        n_compared++;
        if (rd_count - base !== 5) begin n_mismatched++; $display("[TB] FAIL read_strobes: got %0d expected 5", rd_count - base); end
        for (int k = 0; k < 4; k++) begin
            n_compared++;
            if (rd_log[(base + k) % 64] !== 16'h0010 + 16'(k)) begin
                n_mismatched++; $display("[TB] FAIL read_addr%0d: got %h expected %h", k, rd_log[(base + k) % 64], 16'h0010 + 16'(k));
            end
        end
        n_compared++;
        if (rd_runs !== runs) begin n_mismatched++; $display("[TB] FAIL read_strobe_width: got %0d long strobes expected 0", rd_runs - runs); end
        n_compared++;
        if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL read_busy_end: got %b expected 0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] rx;
        int base = rd_count;
        ss_begin();
        send_read(24'h00FFFF);
        spi_byte(8'h00, rx);
        n_compared++;
        if (rx !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL wrap_byte0: got %h expected a5", rx); end
        spi_byte(8'h00, rx);
        n_compared++;
        if (rx !== 8'h5A) begin n_mismatched++; $display("[TB] FAIL wrap_byte1: got %h expected 5a", rx); end
        ss_end();
        n_compared++;
        if (rd_log[base % 64] !== 16'hFFFF) begin n_mismatched++; $display("[TB] FAIL wrap_addr0: got %h expected ffff", rd_log[base % 64]); end
        n_compared++;
        if (rd_log[(base + 1) % 64] !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL wrap_addr1: got %h expected 0000", rd_log[(base + 1) % 64]); end
    endtask

    task automatic test_jedec();
        logic [7:0] exp_id [4] = '{8'hEF, 8'h40, 8'h16, 8'h00};
        logic [7:0] rx;
        ss_begin();
        spi_byte(8'h9F, rx);
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, rx);
            n_compared++;
            if (rx !== exp_id[k]) begin n_mismatched++; $display("[TB] FAIL jedec_byte%0d: got %h expected %h", k, rx, exp_id[k]); end
        end
        ss_end();
    endtask

    task automatic test_status();
        logic [7:0] rx;
        ss_begin();
        spi_byte(8'h05, rx);
        for (int k = 0; k < 2; k++) begin
            spi_byte(8'h00, rx);
            n_compared++;
            if (rx !== 8'h00) begin n_mismatched++; $display("[TB] FAIL status_byte%0d: got %h expected 00", k, rx); end
        end
        ss_end();
    endtask

    task automatic test_ignore();
        logic [7:0] rx;
        int base = rd_count;
        int mh;
        ss_begin();
        mh = miso_hi;
        spi_byte(8'hAB, rx);
        n_compared++;
        if (bus.spi_miso_oe !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ignore_oe: got %b expected 1", bus.spi_miso_oe); end
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        n_compared++;
        if (miso_hi !== mh) begin n_mismatched++; $display("[TB] FAIL ignore_miso: got %0d high samples expected 0", miso_hi - mh); end
        ss_end();
        n_compared++;
        if (rd_count !== base) begin n_mismatched++; $display("[TB] FAIL ignore_rd: got %0d strobes expected 0", rd_count - base); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic b;
        int base = rd_count;
        ss_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        for (int k = 0; k < 4; k++) spi_bit(1'b0, b);
        repeat (2) @(negedge io_clock);
        bus.spi_ss = 1'b1;
        repeat (6) @(negedge io_clock);
        n_compared++;
        if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
        n_compared++;
        if (rd_count !== base) begin n_mismatched++; $display("[TB] FAIL abort_rd: got %0d strobes expected 0", rd_count - base); end
        ss_begin();
        send_read(24'h000020);
        spi_byte(8'h00, rx);
        ss_end();
        n_compared++;
        if (rx !== 8'h7A) begin n_mismatched++; $display("[TB] FAIL abort_reread: got %h expected 7a", rx); end
        n_compared++;
        if (rd_log[base % 64] !== 16'h0020) begin n_mismatched++; $display("[TB] FAIL abort_addr: got %h expected 0020", rd_log[base % 64]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic b;
        int base, oh, bh;
        ss_begin();
        send_read(24'h000010);
        for (int k = 0; k < 4; k++) spi_bit(1'b0, b);
        repeat (3) @(negedge io_clock);
        // Bit 3 of 0x4A is a one, so MISO is high just before the reset.
        n_compared++;
        if (bus.spi_miso !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_pre_miso: got %b expected 1", bus.spi_miso); end
        io_reset = 1'b1;
        #1;
        n_compared++;
        if (bus.spi_miso !== 1'b0 || bus.spi_miso_oe !== 1'b0 || bus.busy !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL midreset_outputs: got miso/oe/busy %b%b%b expected 000", bus.spi_miso, bus.spi_miso_oe, bus.busy);
        end
        n_compared++;
        if (bus.mem_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL midreset_addr: got %h expected 0000", bus.mem_addr); end
        repeat (3) @(negedge io_clock);
        io_reset = 1'b0;
        repeat (4) @(negedge io_clock);
        base = rd_count;
        oh = oe_hi;
        bh = busy_hi;
        send_read(24'h000010);
        spi_byte(8'h00, rx);
        n_compared++;
        if (rx !== 8'h00) begin n_mismatched++; $display("[TB] FAIL stale_ss_miso: got %h expected 00", rx); end
        n_compared++;
        if (oe_hi !== oh || busy_hi !== bh) begin
            n_mismatched++; $display("[TB] FAIL stale_ss_oe_busy: got %0d/%0d high samples expected 0/0", oe_hi - oh, busy_hi - bh);
        end
        n_compared++;
        if (rd_count !== base) begin n_mismatched++; $display("[TB] FAIL stale_ss_rd: got %0d strobes expected 0", rd_count - base); end
        ss_end();
        ss_begin();
        send_read(24'h000010);
        spi_byte(8'h00, rx);
        ss_end();
        n_compared++;
        if (rx !== 8'h4A) begin n_mismatched++; $display("[TB] FAIL post_reset_read: got %h expected 4a", rx); end
    endtask

    initial begin
        io_reset     = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_ss   = 1'b1;
        bus.spi_mosi = 1'b0;
        test_reset();
        test_read();
        test_wrap();
        test_jedec();
        test_status();
        test_ignore();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
